// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter: FSM state
// encodings and a constant clog2 helper used to size the bit counter.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter tracking the data bits still to send; it saturates
// at zero so an idle serializer never wraps.
module bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero_next
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // High on the edge that consumes the last remaining bit.
  assign zero_next = dec && !load && (count == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out transmitter with a valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy,
  output logic             done
);

  // Handshake: a word transfers on a rising edge where load_valid and
  // load_ready are both high; load_ready is high exactly in IDLE, and
  // load_valid/data_in are ignored in every other state.

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   count;
  logic               last_bit;
  logic               load_fire;
  logic               shift_en;
  logic               done_next;
`ifdef PISO_PARITY_EN
  logic               parity;
`endif

  assign load_fire = (state == ST_IDLE) && load_valid;
  assign shift_en  = (state == ST_SHIFT) && enable;

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_fire),
    .load_value (CNT_W'(WIDTH)),
    .dec        (shift_en),
    .count      (count),
    .zero_next  (last_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load_fire) begin
      shreg <= data_in;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (load_fire) begin
      parity <= ^data_in;
    end
  end
`endif

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_IDLE;
          done_next  = 1'b1;
`endif
        end
      end
      ST_PARITY: begin
`ifdef PISO_PARITY_EN
        if (enable) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_first = 1'b0;
    busy       = 1'b0;
    load_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SHIFT: begin
        sout       = shreg[WIDTH-1];
        sout_valid = 1'b1;
        sout_first = (count == CNT_W'(WIDTH));
        busy       = 1'b1;
      end
      ST_PARITY: begin
`ifdef PISO_PARITY_EN
        sout       = parity;
        sout_valid = 1'b1;
        busy       = 1'b1;
`endif
      end
      default: load_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=16 and WIDTH=2 instances);
// honours PISO_PARITY_EN when the build defines it.
module tb_piso_serializer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic [15:0] data_in;
  logic        load_ready, sout, sout_valid, sout_first, busy, done;

  logic        enable2;
  logic        load_valid2;
  logic [1:0]  data_in2;
  logic        load_ready2, sout2, sout_valid2, sout_first2, busy2, done2;

  int vectors;
  int errs;

  piso_serializer #(.WIDTH(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_first (sout_first),
    .busy       (busy),
    .done       (done)
  );

  piso_serializer #(.WIDTH(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable2),
    .load_valid (load_valid2),
    .load_ready (load_ready2),
    .data_in    (data_in2),
    .sout       (sout2),
    .sout_valid (sout_valid2),
    .sout_first (sout_first2),
    .busy       (busy2),
    .done       (done2)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sout"},       sout,       1'b0);
    chk({tag, " sout_valid"}, sout_valid, 1'b0);
    chk({tag, " sout_first"}, sout_first, 1'b0);
    chk({tag, " busy"},       busy,       1'b0);
    chk({tag, " done"},       done,       1'b0);
    chk({tag, " load_ready"}, load_ready, 1'b1);
  endtask

  // Load word with enable held high and check every bit plus the done cycle.
  task automatic send_continuous(input string tag, input logic [15:0] word, input logic par_exp);
    load_valid = 1'b1;
    data_in    = word;
    enable     = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 16; i++) begin
      chk({tag, " sout"},       sout,       word[15-i]);
      chk({tag, " sout_first"}, sout_first, (i == 0));
      chk({tag, " sout_valid"}, sout_valid, 1'b1);
      chk({tag, " load_ready"}, load_ready, 1'b0);
      chk({tag, " done early"}, done,       1'b0);
      tick();
    end
`ifdef PISO_PARITY_EN
    chk({tag, " parity bit"},   sout,       par_exp);
    chk({tag, " parity valid"}, sout_valid, 1'b1);
    chk({tag, " parity first"}, sout_first, 1'b0);
    chk({tag, " parity done"},  done,       1'b0);
    tick();
`else
    chk({tag, " no parity"}, {31'd0, par_exp} ^ {31'd0, par_exp}, 32'd0);
`endif
    chk({tag, " done"},       done,       1'b1);
    chk({tag, " done ready"}, load_ready, 1'b1);
    chk({tag, " done busy"},  busy,       1'b0);
    tick();
    chk({tag, " done pulse"}, done,       1'b0);
  endtask

  initial begin
    logic [15:0] gap_word;
    logic [3:0]  gap_pat;
    int k;
    int c;

    vectors     = 0;
    errs        = 0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    data_in     = '0;
    enable2     = 1'b0;
    load_valid2 = 1'b0;
    data_in2    = '0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    #2;
    chk_reset_outputs("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("post reset idle");

    // Continuous enable, enable and load_valid together in IDLE.
    send_continuous("cont a5c3", 16'hA5C3, 1'b0);

    // Gapped enable 1,0,0,1 with 8001: bits 1, fourteen 0s, 1.
    gap_word   = 16'h8001;
    gap_pat    = 4'b1001;
    load_valid = 1'b1;
    data_in    = gap_word;
    enable     = 1'b0;
    tick();
    load_valid = 1'b0;
    k = 0;
    c = 0;
    while (k < 16 && c < 200) begin
      enable = gap_pat[3 - (c % 4)];
      chk("gap sout", sout, (k == 0 || k == 15));
      chk("gap busy", busy, 1'b1);
      chk("gap done", done, 1'b0);
      tick();
      if (enable) k++;
      c++;
    end
    chk("gap edge budget", k, 16);
`ifdef PISO_PARITY_EN
    enable = 1'b0;
    tick();
    chk("gap parity held", sout, 1'b0);
    enable = 1'b1;
    tick();
`endif
    chk("gap final done", done, 1'b1);
    enable = 1'b0;
    tick();

    // Load during busy: FFFF offered for the whole 0000 frame.
    load_valid = 1'b1;
    data_in    = 16'h0000;
    enable     = 1'b1;
    tick();
    data_in = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      chk("busy load_ready", load_ready, 1'b0);
      chk("busy sout zero", sout, 1'b0);
      tick();
    end
`ifdef PISO_PARITY_EN
    chk("busy parity zero", sout, 1'b0);
    tick();
`endif
    chk("busy done", done, 1'b1);
    chk("busy done ready", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    chk("ffff first bit", sout, 1'b1);
    chk("ffff first flag", sout_first, 1'b1);
    chk("ffff done low", done, 1'b0);

    // Asynchronous reset mid-frame, five bits in.
    for (int i = 0; i < 5; i++) tick();
    chk("mid frame busy", busy, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    tick();
    chk("reset no done 1", done, 1'b0);
    tick();
    chk("reset no done 2", done, 1'b0);
    reset = 1'b1;
    tick();
    chk("after reset done", done, 1'b0);

    send_continuous("post reset 8001", 16'h8001, 1'b0);
    send_continuous("parity 0007", 16'h0007, 1'b1);
    send_continuous("parity 0003", 16'h0003, 1'b0);

    // WIDTH=2 instance: 2'b10 then idle with enable high (no wrap).
    load_valid2 = 1'b1;
    data_in2    = 2'b10;
    enable2     = 1'b1;
    tick();
    load_valid2 = 1'b0;
    chk("w2 bit1", sout2, 1'b1);
    chk("w2 first1", sout_first2, 1'b1);
    tick();
    chk("w2 bit0", sout2, 1'b0);
    chk("w2 first0", sout_first2, 1'b0);
    chk("w2 valid", sout_valid2, 1'b1);
    tick();
`ifdef PISO_PARITY_EN
    chk("w2 parity", sout2, 1'b1);
    tick();
`endif
    chk("w2 done", done2, 1'b1);
    chk("w2 ready", load_ready2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w2 idle busy", busy2, 1'b0);
      chk("w2 idle valid", sout_valid2, 1'b0);
      chk("w2 idle done", done2, 1'b0);
    end
    load_valid2 = 1'b1;
    data_in2    = 2'b01;
    tick();
    load_valid2 = 1'b0;
    chk("w2 reload bit1", sout2, 1'b0);
    chk("w2 reload first", sout_first2, 1'b1);
    tick();
    chk("w2 reload bit0", sout2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link that the team's serial-in shift register receives.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per cycle in which `enable` is high.
- Sits between ALU result registers and any bit-serial consumer.

Parameters:
- WIDTH, 16, data word width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  bit-rate strobe; one bit advances per cycle with enable=1.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word.
- data_in  input  WIDTH  parallel word to transmit.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit.
- sout_first  output  1  high while sout is the first (MSB) bit of a frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any state, including mid-frame):
  - state=IDLE, shift register and counter cleared.
  - sout=0, sout_valid=0, sout_first=0, busy=0, done=0, load_ready=1.
  - Any frame in progress is aborted; no done pulse is produced.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- IDLE:
  - load_ready=1, busy=0, sout_valid=0, sout=0.
  - On a rising edge with load_valid=1: capture data_in, set count=WIDTH, go to SHIFT.
  - load_ready drops in the next cycle.
- SHIFT:
  - busy=1, sout_valid=1, load_ready=0.
  - sout=shreg[WIDTH-1], driven from the register, never combinationally from data_in.
  - sout_first=1 while count==WIDTH.
  - On an edge with enable=1: shreg shifts left with 0 fill, count decrements.
  - On an edge with enable=1 and count==1: go to IDLE (or PARITY if enabled) and assert done for exactly the next cycle.
  - enable=0 holds all state; the current bit stays on sout indefinitely.
- Latency:
  - The first bit appears on sout in the cycle after the load handshake.
  - With enable held high, done pulses WIDTH+1 cycles after the handshake.
  - done coincides with the first IDLE cycle, so load_ready=1 in that same cycle.
- Load rules:
  - load_valid is ignored outside IDLE; data_in is don't-care there.
  - Back-to-back words: minimum one IDLE cycle between frames (the handshake cycle).
  - load_valid and enable asserted together in IDLE: the load wins. enable is irrelevant until SHIFT.
- Width rules: count never underflows; it saturates at 0 in IDLE.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - At the load handshake, even parity of data_in (XOR reduction) is captured.
  - After the last data bit, the FSM enters PARITY: sout=parity, sout_valid=1, sout_first=0.
  - It stays in PARITY until an enable=1 edge, then goes to IDLE; done pulses after that edge.
  - Frame length becomes WIDTH+1 bits.
- Undefined: PARITY state, parity register and logic are absent; frame is exactly WIDTH bits.

Decomposition:
- Shared include/package: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2) and a clog2 helper function.
- Sub-module: bit_counter.
  - Loadable down-counter with parameter WIDTH.
  - Ports: clk, reset, load, load_value, dec, count, zero_next.
  - Instantiated once; the FSM and shift register stay in piso_serializer.

Test Plan:
- Reset mid-frame: load 16'hA5C3, shift 5 bits, pulse reset low asynchronously between edges → all outputs at reset values immediately, no done pulse; next load transmits cleanly.
- Continuous enable: load 16'hA5C3 → sout sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on consecutive cycles, sout_first only on the first bit, done at handshake+17.
- Gapped enable: enable pattern 1,0,0,1 repeating with 16'h8001 → each bit held while enable=0, sequence 1, fourteen 0s, 1; done after the 16th enabled edge.
- Load during busy: assert load_valid with 16'hFFFF throughout a 16'h0000 frame → load_ready=0 and output all zeros; 16'hFFFF accepted in the done cycle, first 1 appears in the following cycle.
- PISO_PARITY_EN: load 16'h0007 → 16 data bits, then parity bit 1; load 16'h0003 → parity 0; done follows the 17th enabled bit.
- Edge widths: WIDTH=2, load 2'b10 → sout 1,0, done at handshake+3; count never wraps below 0.
